tx_pulse_sequencer: RTL and testbench
=====================================

# tx_pulse_sequencer

Transmit pulse sequencer for the HFSWR TX chain. It takes the continuous signed sine samples from the DDS and gates them into phase-coded pulses. Each pulse carries a programmable binary code (BPSK, one code bit per chip) and pulses repeat at a programmable pulse-repetition interval (PRI). It sits between the DDS output and the DAC output registers, and replaces the free-running divider/modulator pair with a framed, PRI-locked pulse train.

## Interface
Parameters:
- DW, 14, sample width (signed two's complement)
- CODE_W, 16, maximum code length in bits
- PRI_W, 32, PRI counter width

Ports:
- clk  in  1  sample clock (ADC/DDS clock domain)
- rst  in  1  reset; one clock, reset is synchronous and active-high
- enable  in  1  run request; level-sensitive
- code  in  CODE_W  phase code, transmitted MSB-first from bit code_len-1
- code_len  in  5  chips per pulse, legal 1..CODE_W
- chip_len  in  16  clk cycles per chip, legal ≥1
- pri_len  in  PRI_W  clk cycles between pulse starts, legal ≥ code_len*chip_len+1
- din  in  DW  signed DDS sample, valid every cycle
- dout  out  DW  signed modulated sample; 0 outside pulses
- tx_active  out  1  high while dout carries pulse samples
- pulse_start  out  1  one-cycle strobe at start of each PRI
- chip_idx  out  5  index of the chip currently being sent
- cfg_err  out  1  sticky illegal-config flag; cleared by rst or by the next legal start

## Operation
- FSM states are IDLE, PULSE and LISTEN.
- IDLE:
  - If enable=1 and the config is legal: latch code/code_len/chip_len/pri_len into shadow registers, clear all counters, go to PULSE, and assert pulse_start.
  - If enable=1 and the config is illegal: set cfg_err and stay in IDLE.
- Config is illegal when any of these holds:
  - code_len=0 or code_len>CODE_W
  - chip_len=0
  - pri_len ≤ code_len*chip_len; the product is computed 21 bits wide and zero-extended to PRI_W for the compare.
- PULSE:
  - chip_cnt counts 0..chip_len-1. On wrap, chip_idx increments.
  - The active code bit is b = code[code_len-1-chip_idx].
  - After the last cycle of chip code_len-1, go to LISTEN.
- LISTEN:
  - dout=0 and tx_active=0.
  - When pri_cnt reaches pri_len-1: if enable=1 and the config is legal, relatch and go to PULSE with pulse_start; otherwise go to IDLE.
  - If enable=1 but the config is illegal, set cfg_err and go to IDLE.
- pri_cnt runs from 0 at pulse start and is held at 0 in IDLE.
- Modulation rule: b=1 gives dout=din; b=0 gives dout=-din. Negation saturates, so -(−2^(DW-1)) = 2^(DW-1)-1.
- Deasserting enable mid-pulse or mid-LISTEN does not truncate anything. The current PRI completes, then the FSM enters IDLE.
- Input changes during a PRI have no effect until the next relatch.

## Timing
- Reset values: dout=0, tx_active=0, pulse_start=0, chip_idx=0, cfg_err=0, state=IDLE.
- Start latency: enable=1 in IDLE at cycle t gives pulse_start=1 at t+1, with the state already PULSE.
- dout and tx_active are registered: dout at cycle n+1 is the modulated din of cycle n, for every cycle n in PULSE.
  - The first pulse sample therefore appears at t+2.
  - tx_active is high for exactly code_len*chip_len consecutive cycles.
- pulse_start is coincident with the first PULSE cycle and one cycle ahead of tx_active.
- chip_idx is unregistered relative to the state (it changes with chip_cnt wrap), so it leads dout by one cycle.
- Back-to-back PRIs: pulse_start strobes exactly pri_len cycles apart, with no gap cycle at the LISTEN→PULSE transition.
- rst mid-operation: every output returns to its reset value on the next edge, and the pulse is aborted immediately.
- cfg_err is asserted on the edge after the failed start check.

## Test plan
- Barker-11, basic shape.
  - Stimulus: code=16'h0712, code_len=11, chip_len=4, pri_len=100, din=+1000 constant, enable held.
  - Required response: dout is +1000×12, -1000×12, +1000×4, -1000×8, +1000×4, -1000×4 (44 cycles total), then 0 for 56 cycles.
  - pulse_start is spaced exactly 100 cycles apart and chip_idx steps 0..10.
- Saturation.
  - Stimulus: code=16'h0000, code_len=1, chip_len=3, din=-8192.
  - Required response: dout=+8191 for 3 cycles.
  - Repeat with din=+8191: dout=-8191.
- Illegal config.
  - Stimulus: chip_len=0; then separately code_len=11, chip_len=10, pri_len=110.
  - Required response: cfg_err=1, no pulse_start, tx_active stays 0.
  - A following legal config clears cfg_err and starts a pulse.
- Enable drop mid-pulse.
  - Stimulus: deassert enable at chip 5 of the Barker-11 case.
  - Required response: the pulse completes all 44 samples, LISTEN ends at cycle 100, the FSM goes to IDLE, and no second pulse_start occurs.
- Reset mid-pulse.
  - Stimulus: assert rst for 1 cycle at chip 3.
  - Required response: on the next edge dout=0, tx_active=0, chip_idx=0; a restart yields pulse_start exactly 1 cycle after enable is resampled.
- Config change mid-PRI.
  - Stimulus: change code to 16'hFFFF during LISTEN.
  - Required response: the current PRI is unaffected and the next pulse is all +din.

Source files
------------

// File: rtl/tx_pulse_sequencer.sv
// tx_pulse_sequencer: gates DDS samples into BPSK phase-coded pulses that
// repeat every pri_len clocks. Config is shadowed at each pulse start so
// input changes only take effect on the next relatch.
//
// Handshake: no valid/ready pair. din is consumed every cycle; dout and
// tx_active are registered one cycle behind the PULSE state, while
// pulse_start and chip_idx follow the state and lead dout by one cycle.
module tx_pulse_sequencer #(
  parameter int DW     = 14,
  parameter int CODE_W = 16,
  parameter int PRI_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CODE_W-1:0]    code,
  input  logic [4:0]           code_len,
  input  logic [15:0]          chip_len,
  input  logic [PRI_W-1:0]     pri_len,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout,
  output logic                 tx_active,
  output logic                 pulse_start,
  output logic [4:0]           chip_idx,
  output logic                 cfg_err,
  output logic [1:0]           state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PULSE  = 2'd1;
  localparam logic [1:0] S_LISTEN = 2'd2;

  localparam logic signed [DW-1:0] D_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] D_MAX = {1'b0, {(DW-1){1'b1}}};

  logic [1:0]          state_next;
  logic [CODE_W-1:0]   code_s;
  logic [4:0]          code_len_s;
  logic [15:0]         chip_len_s;
  logic [PRI_W-1:0]    pri_len_s;
  logic [15:0]         chip_cnt;
  logic [PRI_W-1:0]    pri_cnt;

  logic [20:0]         pulse_cycles;
  logic                cfg_legal;
  logic                start_ok;
  logic                start_check;
  logic                load;
  logic                start_fail;
  logic                chip_end;
  logic                last_chip;
  logic                pri_end;
  logic [4:0]          bit_pos;
  logic [CODE_W-1:0]   code_shift;
  logic                code_bit;
  logic signed [DW-1:0] din_neg;
  logic signed [DW-1:0] mod_sample;

  // Config legality on the live inputs plus the start/relatch decision points
  always_comb begin
    pulse_cycles = 21'(code_len) * 21'(chip_len);
    cfg_legal    = (code_len != 5'd0) && (int'(code_len) <= CODE_W) &&
                   (chip_len != 16'd0) && (pri_len > PRI_W'(pulse_cycles));
    chip_end     = (chip_cnt == chip_len_s - 16'd1);
    last_chip    = (chip_idx == code_len_s - 5'd1);
    pri_end      = (pri_cnt == pri_len_s - PRI_W'(1));
    start_check  = (state == S_IDLE) || ((state == S_LISTEN) && pri_end);
    start_ok     = enable && cfg_legal;
    load         = start_check && start_ok;
    start_fail   = start_check && enable && !cfg_legal;
  end

  // Code bit selection (MSB-first) and saturating BPSK modulation
  always_comb begin
    bit_pos    = code_len_s - 5'd1 - chip_idx;
    code_shift = code_s >> bit_pos;
    code_bit   = code_shift[0];
    din_neg    = (din == D_MIN) ? D_MAX : -din;
    mod_sample = code_bit ? din : din_neg;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (load) state_next = S_PULSE;
      S_PULSE:  if (chip_end && last_chip) state_next = S_LISTEN;
      S_LISTEN: if (pri_end) state_next = load ? S_PULSE : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Unregistered FSM output: strobe on the first PULSE cycle of each PRI
  always_comb begin
    pulse_start = (state == S_PULSE) && (pri_cnt == '0);
  end

  // Shadow config and chip/PRI counters
  always_ff @(posedge clk) begin
    if (rst) begin
      code_s     <= '0;
      code_len_s <= '0;
      chip_len_s <= '0;
      pri_len_s  <= '0;
      chip_cnt   <= '0;
      chip_idx   <= '0;
      pri_cnt    <= '0;
    end else if (load) begin
      code_s     <= code;
      code_len_s <= code_len;
      chip_len_s <= chip_len;
      pri_len_s  <= pri_len;
      chip_cnt   <= '0;
      chip_idx   <= '0;
      pri_cnt    <= '0;
    end else begin
      case (state)
        S_PULSE: begin
          pri_cnt <= pri_cnt + PRI_W'(1);
          if (chip_end) begin
            chip_cnt <= '0;
            chip_idx <= last_chip ? 5'd0 : chip_idx + 5'd1;
          end else begin
            chip_cnt <= chip_cnt + 16'd1;
          end
        end
        S_LISTEN: pri_cnt <= pri_end ? '0 : pri_cnt + PRI_W'(1);
        default: begin
          chip_cnt <= '0;
          chip_idx <= '0;
          pri_cnt  <= '0;
        end
      endcase
    end
  end

  // Registered sample path and sticky config error
  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      tx_active <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      dout      <= (state == S_PULSE) ? mod_sample : '0;
      tx_active <= (state == S_PULSE);
      if (start_fail)  cfg_err <= 1'b1;
      else if (load)   cfg_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_pulse_sequencer.sv
// Testbench for tx_pulse_sequencer: expected pulse samples are queued when a
// configuration is driven and popped whenever the DUT shows tx_active.
module tb_tx_pulse_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [15:0]        code;
  logic [4:0]         code_len;
  logic [15:0]        chip_len;
  logic [31:0]        pri_len;
  logic signed [13:0] din;
  logic signed [13:0] dout;
  logic               tx_active;
  logic               pulse_start;
  logic [4:0]         chip_idx;
  logic               cfg_err;
  logic [1:0]         state;

  logic signed [13:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ps = -1;
  int ps_count = 0;
  int k = -1;
  int cur_chip = 1;
  int cur_n = 0;
  int cur_pri = 0;

  tx_pulse_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .code(code), .code_len(code_len),
    .chip_len(chip_len), .pri_len(pri_len), .din(din), .dout(dout),
    .tx_active(tx_active), .pulse_start(pulse_start), .chip_idx(chip_idx),
    .cfg_err(cfg_err), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int neg_sat(input int v);
    return (v == -8192) ? 8191 : -v;
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (tx_active) begin
      if (exp_q.size() == 0) check("sb_underflow", int'(tx_active), 0);
      else check("dout", int'(dout), int'(exp_q.pop_front()));
    end else begin
      check("dout_idle", int'(dout), 0);
    end
    if (pulse_start) begin
      if (last_ps >= 0) check("pri_spacing", cyc - last_ps, cur_pri);
      last_ps = cyc;
      ps_count++;
      k = 0;
    end
    if (k >= 0) begin
      if (k < cur_n) check("chip_idx", int'(chip_idx), k / cur_chip);
      k++;
    end
  end

  // driver tasks
  task automatic push_pulse(input logic [15:0] c, input int cl, input int chl, input int d);
    logic b;
    for (int i = 0; i < cl; i++) begin
      b = c[cl-1-i];
      for (int j = 0; j < chl; j++) exp_q.push_back(14'(b ? d : neg_sat(d)));
    end
  endtask

  task automatic set_cfg(input logic [15:0] c, input int cl, input int chl, input int pri, input int d);
    code = c; code_len = 5'(cl); chip_len = 16'(chl); pri_len = 32'(pri); din = 14'(d);
    cur_chip = (chl > 0) ? chl : 1; cur_n = cl * chl; cur_pri = pri; last_ps = -1; k = -1;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("start_lat", int'(pulse_start), 1);
    check("start_state", int'(state), 1);
  endtask

  task automatic wait_ps(input int target, input int budget);
    for (int i = 0; i < budget && ps_count < target; i++) @(negedge clk);
    if (ps_count < target) check("ps_timeout", ps_count, target);
  endtask

  task automatic finish_run(input int pri);
    repeat (pri + 5) @(negedge clk);
    check("sb_leftover", exp_q.size(), 0);
    check("end_idle", int'(state), 0);
  endtask

  task automatic run_cfg(input logic [15:0] c, input int cl, input int chl, input int pri,
                         input int d, input int np);
    int base;
    set_cfg(c, cl, chl, pri, d);
    for (int p = 0; p < np; p++) push_pulse(c, cl, chl, d);
    base = ps_count;
    start_pulse();
    wait_ps(base + np, np * pri + 20);
    enable = 1'b0;
    finish_run(pri);
    check("ps_total", ps_count - base, np);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; k = -1; last_ps = -1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic illegal_case(input int cl, input int chl, input int pri);
    int base;
    pulse_reset();
    check("err_cleared_by_rst", int'(cfg_err), 0);
    set_cfg(16'h0712, cl, chl, pri, 1000);
    base = ps_count;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("cfg_err_set", int'(cfg_err), 1);
    check("illegal_no_tx", int'(tx_active), 0);
    check("illegal_no_ps", ps_count - base, 0);
    enable = 1'b0;
  endtask

  initial begin
    int base;
    int cl, chl;
    rst = 1'b1; enable = 1'b0;
    set_cfg(16'h0000, 1, 1, 10, 0);
    repeat (3) @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_tx", int'(tx_active), 0);
    check("rst_ps", int'(pulse_start), 0);
    check("rst_chip", int'(chip_idx), 0);
    check("rst_err", int'(cfg_err), 0);
    check("rst_state", int'(state), 0);
    rst = 1'b0;

    // Barker-11, two back-to-back PRIs
    run_cfg(16'h0712, 11, 4, 100, 1000, 2);

    // saturation in both directions
    run_cfg(16'h0000, 1, 3, 10, -8192, 1);
    run_cfg(16'h0000, 1, 3, 10, 8191, 1);

    // illegal configs, then a legal start clears cfg_err
    illegal_case(11, 0, 100);
    illegal_case(11, 10, 110);
    illegal_case(0, 4, 100);
    illegal_case(17, 1, 100);
    set_cfg(16'h0712, 11, 10, 111, 500);
    push_pulse(16'h0712, 11, 10, 500);
    start_pulse();
    check("err_cleared_by_start", int'(cfg_err), 0);
    enable = 1'b0;
    finish_run(111);

    // enable drop at chip 5: PRI completes, then IDLE at cycle 100
    set_cfg(16'h0712, 11, 4, 100, -1234);
    push_pulse(16'h0712, 11, 4, -1234);
    base = ps_count;
    start_pulse();
    repeat (20) @(negedge clk);
    check("drop_chip5", int'(chip_idx), 5);
    enable = 1'b0;
    repeat (79) @(negedge clk);
    check("drop_listen_99", int'(state), 2);
    @(negedge clk);
    check("drop_idle_100", int'(state), 0);
    finish_run(100);
    check("drop_one_ps", ps_count - base, 1);

    // reset at chip 3, then restart with enable still high
    set_cfg(16'h0712, 11, 4, 100, 2000);
    push_pulse(16'h0712, 11, 4, 2000);
    start_pulse();
    repeat (12) @(negedge clk);
    check("pre_rst_chip3", int'(chip_idx), 3);
    rst = 1'b1; k = -1; last_ps = -1;
    @(negedge clk);
    check("midrst_dout", int'(dout), 0);
    check("midrst_tx", int'(tx_active), 0);
    check("midrst_chip", int'(chip_idx), 0);
    check("midrst_state", int'(state), 0);
    rst = 1'b0;
    exp_q.delete();
    push_pulse(16'h0712, 11, 4, 2000);
    @(negedge clk);
    check("restart_lat", int'(pulse_start), 1);
    enable = 1'b0;
    finish_run(100);

    // code change during LISTEN only affects the next pulse
    set_cfg(16'h0712, 11, 4, 100, 777);
    push_pulse(16'h0712, 11, 4, 777);
    push_pulse(16'hFFFF, 11, 4, 777);
    base = ps_count;
    start_pulse();
    repeat (60) @(negedge clk);
    code = 16'hFFFF;
    wait_ps(base + 2, 200);
    enable = 1'b0;
    finish_run(100);

    // random legal configs, including the shortest legal PRI and full-length code
    for (int r = 0; r < 5; r++) begin
      cl  = (r == 0) ? 16 : $urandom_range(1, 16);
      chl = $urandom_range(1, 4);
      run_cfg(16'($urandom), cl, chl, cl * chl + ((r < 2) ? 1 : $urandom_range(1, 10)),
              $urandom_range(0, 16383) - 8192, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
